// File: rtl/hash_reg_bank_irq_if.sv
// Purpose : SPI-side register access bus between the SPI slave (master) and the register bank (slave).
// Latency : n/a (signal bundle only).
// Backpressure: none; strobes are single-cycle and always accepted.
// Signals : address/data_in/read_strobe/write_strobe from master, registered data_out from slave.
interface hash_reg_bank_irq_if;
    logic [7:0] address;
    logic [7:0] data_in;
    logic       read_strobe;
    logic       write_strobe;
    logic [7:0] data_out;

    modport master (
        output address,
        output data_in,
        output read_strobe,
        output write_strobe,
        input  data_out
    );

    modport slave (
        input  address,
        input  data_in,
        input  read_strobe,
        input  write_strobe,
        output data_out
    );
endinterface

// File: rtl/hash_reg_bank_irq.sv
// Purpose : SPI register bank driving N hash macros, with sticky W1C IRQ status, perf counter snapshot
//           and MACRO_ADDR auto-increment on MACRO_DATA writes.
// Latency : read data one cycle after read_strobe; DATA_WR_STROBE one cycle after a MACRO_DATA write;
//           DATA_AVAILABLE edge reaches IRQ_STATUS SYNC_STAGES+1 cycles after it is applied.
// Backpressure: none; every strobe is accepted in the cycle it is presented.
// Ports   : SPI_CLK/RST_N (clock, async active-low reset); bus (slave modport of register bus);
//           CONTROL-derived pins (HASH_EN, LED_out, hash_clock_reset, ID_out), spi_addr, interrupt_out,
//           macro select vectors, HASH_ADDR/DATA_TO_HASH/DATA_WR_STROBE to the macros, and the
//           asynchronous DATA_AVAILABLE/DATA_FROM_HASH inputs from the macros.
module hash_reg_bank_irq #(
    parameter int         NUM_MACROS  = 4,
    parameter int         CNT_WIDTH   = 32,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] ID_VALUE    = 8'h12
) (
    input  logic                  SPI_CLK,
    input  logic                  RST_N,
    hash_reg_bank_irq_if.slave    bus,
    output logic                  hash_clock_reset,
    output logic                  LED_out,
    output logic                  ID_out,
    output logic [6:0]            spi_addr,
    output logic                  interrupt_out,
    output logic                  HASH_EN,
    output logic [NUM_MACROS-1:0] MACRO_WR_SELECT,
    output logic [NUM_MACROS-1:0] MACRO_RD_SELECT,
    output logic [5:0]            HASH_ADDR,
    output logic [7:0]            DATA_TO_HASH,
    output logic                  DATA_WR_STROBE,
    input  logic [NUM_MACROS-1:0] DATA_AVAILABLE,
    input  logic [7:0]            DATA_FROM_HASH
);

    localparam logic [CNT_WIDTH-1:0] PERF_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Register state
    logic [7:0]            r_macro_addr;
    logic [NUM_MACROS-1:0] r_rd_sel;
    logic [5:0]            r_ctrl;        // CONTROL[5:0]; [6] is a self-clearing action, [7] unused
    logic [7:0]            r_spi_addr;
    logic [NUM_MACROS-1:0] r_wr_sel;
    logic [NUM_MACROS-1:0] r_irq_status;
    logic [NUM_MACROS-1:0] r_irq_mask;
    logic [CNT_WIDTH-1:0]  r_perf;
    logic [CNT_WIDTH-1:0]  r_snap;
    logic [7:0]            r_data_to_hash;
    logic                  r_wr_strobe;
    logic [7:0]            r_data_out;

    // Synchronisers for the hash-side asynchronous inputs
    logic [NUM_MACROS-1:0] r_da_sync  [SYNC_STAGES];
    logic [7:0]            r_dfh_sync [SYNC_STAGES];
    logic [NUM_MACROS-1:0] r_da_prev;

    // Decode
    logic                  w_wr_addr;
    logic                  w_wr_data;
    logic                  w_wr_rdsel;
    logic                  w_wr_ctrl;
    logic                  w_wr_spi;
    logic                  w_wr_wrsel;
    logic                  w_wr_stat;
    logic                  w_wr_mask;
    logic                  w_rd_perf0;
    logic [NUM_MACROS-1:0] w_da_sync;
    logic [NUM_MACROS-1:0] w_da_rise;
    logic [NUM_MACROS-1:0] w_w1c;
    logic [31:0]           w_perf32;
    logic [31:0]           w_snap32;
    logic [7:0]            w_rd_dat;

    assign w_wr_addr  = bus.write_strobe && (bus.address == 8'h00);
    assign w_wr_data  = bus.write_strobe && (bus.address == 8'h01);
    assign w_wr_rdsel = bus.write_strobe && (bus.address == 8'h02);
    assign w_wr_ctrl  = bus.write_strobe && (bus.address == 8'h03);
    assign w_wr_spi   = bus.write_strobe && (bus.address == 8'h04);
    assign w_wr_wrsel = bus.write_strobe && (bus.address == 8'h05);
    assign w_wr_stat  = bus.write_strobe && (bus.address == 8'h08);
    assign w_wr_mask  = bus.write_strobe && (bus.address == 8'h09);
    assign w_rd_perf0 = bus.read_strobe  && (bus.address == 8'h0A);

    assign w_da_sync = r_da_sync[SYNC_STAGES-1];
    assign w_da_rise = w_da_sync & ~r_da_prev;
    assign w_w1c     = w_wr_stat ? bus.data_in[NUM_MACROS-1:0] : '0;

    // Zero-extend the counter and snapshot so byte lanes above CNT_WIDTH read 0
    assign w_perf32 = 32'(r_perf);
    assign w_snap32 = 32'(r_snap);

    // Read mux sees current (pre-write) register values, so a read and write to the
    // same address in one cycle returns the old contents.
    always_comb begin
        w_rd_dat = 8'h00;
        if (bus.address[7]) begin
            w_rd_dat = r_dfh_sync[SYNC_STAGES-1];
        end else begin
            case (bus.address[6:0])
                7'h00:   w_rd_dat = r_macro_addr;
                7'h02:   w_rd_dat = 8'(r_rd_sel);
                7'h03:   w_rd_dat = {2'b00, r_ctrl};
                7'h04:   w_rd_dat = r_spi_addr;
                7'h05:   w_rd_dat = 8'(r_wr_sel);
                7'h06:   w_rd_dat = ID_VALUE;
                7'h07:   w_rd_dat = {4'(NUM_MACROS), 4'd6};
                7'h08:   w_rd_dat = 8'(r_irq_status);
                7'h09:   w_rd_dat = 8'(r_irq_mask);
                7'h0A:   w_rd_dat = w_perf32[7:0];
                7'h0B:   w_rd_dat = w_snap32[15:8];
                7'h0C:   w_rd_dat = w_snap32[23:16];
                7'h0D:   w_rd_dat = w_snap32[31:24];
                default: w_rd_dat = 8'h00;
            endcase
        end
    end

    // Synchronisers and edge detect
    always_ff @(posedge SPI_CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_da_sync[i]  <= '0;
                r_dfh_sync[i] <= '0;
            end
            r_da_prev <= '0;
        end else begin
            r_da_sync[0]  <= DATA_AVAILABLE;
            r_dfh_sync[0] <= DATA_FROM_HASH;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_da_sync[i]  <= r_da_sync[i-1];
                r_dfh_sync[i] <= r_dfh_sync[i-1];
            end
            r_da_prev <= w_da_sync;
        end
    end

    // Configuration registers and macro write path
    always_ff @(posedge SPI_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_macro_addr   <= '0;
            r_rd_sel       <= '0;
            r_ctrl         <= '0;
            r_spi_addr     <= '0;
            r_wr_sel       <= '0;
            r_irq_mask     <= '0;
            r_data_to_hash <= '0;
            r_wr_strobe    <= 1'b0;
        end else begin
            r_wr_strobe <= w_wr_data;
            if (w_wr_data) begin
                r_data_to_hash <= bus.data_in;
                // Auto-increment only walks the 6-bit macro address; [7:6] are preserved
                if (r_ctrl[1]) begin
                    r_macro_addr <= {r_macro_addr[7:6], r_macro_addr[5:0] + 6'd1};
                end
            end
            if (w_wr_addr)  r_macro_addr <= bus.data_in;
            if (w_wr_rdsel) r_rd_sel     <= bus.data_in[NUM_MACROS-1:0];
            if (w_wr_ctrl)  r_ctrl       <= bus.data_in[5:0];
            if (w_wr_spi)   r_spi_addr   <= bus.data_in;
            if (w_wr_wrsel) r_wr_sel     <= bus.data_in[NUM_MACROS-1:0];
            if (w_wr_mask)  r_irq_mask   <= bus.data_in[NUM_MACROS-1:0];
        end
    end

    // Sticky interrupt status: a rising edge in the same cycle as a W1C keeps the bit set.
    // The mask only gates interrupt_out, never capture.
    always_ff @(posedge SPI_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_irq_status <= '0;
        end else begin
            r_irq_status <= (r_irq_status & ~w_w1c) | w_da_rise;
        end
    end

    // Perf counter, snapshot and registered read data
    always_ff @(posedge SPI_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_perf     <= '0;
            r_snap     <= '0;
            r_data_out <= '0;
        end else begin
            if (w_wr_ctrl && bus.data_in[6]) begin
                r_perf <= '0;
            end else if (r_ctrl[2]) begin
                r_perf <= r_perf + PERF_ONE;
            end
            // Reading the low byte freezes the whole count so the upper bytes
            // read afterwards belong to the same value.
            if (w_rd_perf0) r_snap <= r_perf;
            if (bus.read_strobe) r_data_out <= w_rd_dat;
        end
    end

    assign bus.data_out      = r_data_out;
    assign HASH_EN           = r_ctrl[0];
    assign LED_out           = r_ctrl[3];
    assign hash_clock_reset  = r_ctrl[4];
    assign ID_out            = r_ctrl[5];
    assign spi_addr          = r_spi_addr[6:0];
    assign interrupt_out     = |(r_irq_status & r_irq_mask);
    assign MACRO_WR_SELECT   = r_wr_sel;
    assign MACRO_RD_SELECT   = r_rd_sel;
    assign HASH_ADDR         = r_macro_addr[5:0];
    assign DATA_TO_HASH      = r_data_to_hash;
    assign DATA_WR_STROBE    = r_wr_strobe;

endmodule
